// File: rtl/dac_pkg.sv
// Shared types and frame helpers for the MCP4901-class DAC serialiser.
package dac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    LATCH
  } state_e;

  localparam int         FRAME_W          = 16;
  localparam int         SAMPLE_W         = 8;
  localparam logic [3:0] CFG_BITS_DEFAULT = 4'b0011;
  localparam logic [3:0] LAST_BIT         = 4'(FRAME_W - 1);

  // Write command: control nibble, 8-bit code, four don't-care bits sent as zero.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [3:0]          cfg,
    input logic [SAMPLE_W-1:0] code
  );
    return {cfg, code, 4'b0000};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period divider: tick is high on the last cycle of every CLK_DIV-cycle window.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  assign tick = (div_cnt_q == LAST);

  // Wrapping on tick keeps each state window aligned to its entry edge.
  always_comb begin
    div_cnt_d = div_cnt_q + 8'd1;
    if (clear || tick) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises one 8-bit DAC code per handshake into a 16-bit SPI mode-0 write,
// then strobes LDAC so the analog output updates once per sample.
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int         CLK_DIV  = 4,
  parameter int         DATA_W   = 8,
  parameter logic [3:0] CFG_BITS = CFG_BITS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_cs_n,
  output logic              dac_ldac_n,
  output logic              busy,
  output logic              frame_done
);

  state_e             state_q;
  logic [FRAME_W-1:0] shift_q;
  logic [3:0]         bit_cnt_q;
  logic               sclk_q;
  logic               mosi_q;
  logic               cs_n_q;
  logic               ldac_n_q;
  logic               busy_q;
  logic               frame_done_q;

  logic               tick;
  logic               accept;
  logic [FRAME_W-1:0] frame_d;

  assign sample_ready = (state_q == IDLE) && rst_n;
  assign accept       = sample_valid && sample_ready;
  assign frame_d      = build_frame(CFG_BITS, sample_in);

  // Divider sits at zero through IDLE so SETUP always gets a full window.
  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q == IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      ldac_n_q     <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= SETUP;
            busy_q    <= 1'b1;
            cs_n_q    <= 1'b0;
            mosi_q    <= frame_d[FRAME_W-1];
            shift_q   <= {frame_d[FRAME_W-2:0], 1'b0};
            bit_cnt_q <= '0;
          end
        end
        SETUP: begin
          if (tick) begin
            state_q <= SHIFT_HI;
            sclk_q  <= 1'b1;
          end
        end
        SHIFT_HI: begin
          // Data moves only on the falling edge, giving a full half-period of hold.
          if (tick) begin
            state_q <= SHIFT_LO;
            sclk_q  <= 1'b0;
            if (bit_cnt_q != LAST_BIT) begin
              mosi_q  <= shift_q[FRAME_W-1];
              shift_q <= {shift_q[FRAME_W-2:0], 1'b0};
            end
          end
        end
        SHIFT_LO: begin
          if (tick) begin
            if (bit_cnt_q != LAST_BIT) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              state_q   <= SHIFT_HI;
              sclk_q    <= 1'b1;
            end else begin
              state_q  <= LATCH;
              cs_n_q   <= 1'b1;
              mosi_q   <= 1'b0;
              ldac_n_q <= 1'b0;
            end
          end
        end
        LATCH: begin
          if (tick) begin
            state_q      <= IDLE;
            ldac_n_q     <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          sclk_q   <= 1'b0;
          mosi_q   <= 1'b0;
          cs_n_q   <= 1'b1;
          ldac_n_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;
  assign spi_cs_n   = cs_n_q;
  assign dac_ldac_n = ldac_n_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
